// File: rtl/u409_pkg.sv
// Shared definitions for the U409 flash controller: one-hot state encoding,
// default timing constants, wait-counter width and a load-value helper.
package u409_pkg;

    localparam int CNT_W = 10;

    localparam int READ_WAIT_DEF    = 3;
    localparam int WRITE_PULSE_DEF  = 2;
    localparam int RECOVERY_DEF     = 1;
    localparam int RST_HOLD_DEF     = 20;
    localparam int BUSY_TIMEOUT_DEF = 1023;

    typedef logic [6:0] state_t;

    localparam state_t ST_INIT_RST  = 7'b000_0001;
    localparam state_t ST_INIT_WAIT = 7'b000_0010;
    localparam state_t ST_IDLE      = 7'b000_0100;
    localparam state_t ST_SETUP     = 7'b000_1000;
    localparam state_t ST_STROBE    = 7'b001_0000;
    localparam state_t ST_ACK       = 7'b010_0000;
    localparam state_t ST_RECOVER   = 7'b100_0000;

    // A state that must last N cycles loads N-1: the exit happens on the edge where the count is 0.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned cycles);
        if (cycles == 0) return '0;
        if (cycles > 2**CNT_W) return '1;
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/u409_flash_timer.sv
// Loadable saturating down-counter with a done flag, shared by every timed
// state of the flash controller.
module u409_flash_timer
    import u409_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= RST_VAL;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/u409_flash_ctrl.sv
// Boot/ROM flash access sequencer: wait-stated strobes, ready/busy handling,
// power-on flash reset. Define FLASH_WRITE_EN to enable real write cycles.
module u409_flash_ctrl
    import u409_pkg::*;
#(
    parameter int unsigned READ_WAIT    = READ_WAIT_DEF,
    parameter int unsigned WRITE_PULSE  = WRITE_PULSE_DEF,
    parameter int unsigned RECOVERY     = RECOVERY_DEF,
    parameter int unsigned RST_HOLD     = RST_HOLD_DEF,
    parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic        CLK40,
    input  logic        RESETn,
    input  logic        TSn,
    input  logic        RnW,
    input  logic        FLASH_SPACE,
    input  logic        F_RDY,
    input  logic [23:2] A,
    output logic        F_ENn,
    output logic        F_READn,
    output logic        F_WRITEn,
    output logic        F_RSTn,
    output logic        F_WPn,
    output logic [1:0]  F_BANK,
    output logic        F_ACK,
    output logic        F_TIMEOUT
);

    state_t           state_reg, state_next;
    logic             rdy_meta_reg, rdy_sync_reg;
    logic             pend_reg, rnw_reg;
    logic [1:0]       bank_reg;
    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_val;
    logic             start_live, timeout_hit;
    logic             en_n_next, read_n_next, write_n_next, rst_n_next, wp_n_next, ack_next;
    logic             en_n_reg, read_n_reg, write_n_reg, rst_n_reg, wp_n_reg, ack_reg, timeout_reg;
    logic             unused_addr;

    assign start_live  = !TSn && FLASH_SPACE;
    assign unused_addr = ^{A[23:22], A[19:2]};

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            rdy_meta_reg <= 1'b0;
            rdy_sync_reg <= 1'b0;
        end else begin
            rdy_meta_reg <= F_RDY;
            rdy_sync_reg <= rdy_meta_reg;
        end
    end

    always_ff @(posedge CLK40) begin
        if (!RESETn) state_reg <= ST_INIT_RST;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_INIT_RST:  if (tmr_done) state_next = ST_INIT_WAIT;
            ST_INIT_WAIT: if (rdy_sync_reg) state_next = ST_IDLE;
            ST_IDLE:      if (pend_reg || start_live) state_next = ST_SETUP;
            ST_SETUP: begin
                if (rdy_sync_reg) begin
`ifdef FLASH_WRITE_EN
                    state_next = ST_STROBE;
`else
                    state_next = rnw_reg ? ST_STROBE : ST_ACK;
`endif
                end else if (tmr_done) begin
                    state_next  = ST_ACK;
                    timeout_hit = 1'b1;
                end
            end
            ST_STROBE:    if (tmr_done) state_next = ST_ACK;
            ST_ACK:       state_next = ST_RECOVER;
            ST_RECOVER:   if (tmr_done) state_next = ST_IDLE;
            default:      state_next = ST_INIT_RST;
        endcase
    end

    // Every state change reloads the shared timer with the duration of the state being entered.
    always_comb begin
        tmr_load = (state_next != state_reg);
        tmr_val  = '0;
        case (state_next)
            ST_INIT_RST: tmr_val = CNT_W'(RST_HOLD);
            ST_SETUP:    tmr_val = wait_load(BUSY_TIMEOUT);
            ST_STROBE:   tmr_val = rnw_reg ? wait_load(READ_WAIT) : wait_load(WRITE_PULSE);
            ST_RECOVER:  tmr_val = wait_load(RECOVERY);
            default:     tmr_val = '0;
        endcase
    end

    u409_flash_timer #(
        .RST_VAL (CNT_W'(RST_HOLD))
    ) u_timer (
        .clk      (CLK40),
        .rst_n    (RESETn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // A start seen while the flash is still coming out of reset is parked and replayed from IDLE.
    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            pend_reg <= 1'b0;
            rnw_reg  <= 1'b1;
            bank_reg <= 2'b00;
        end else if (state_reg == ST_INIT_WAIT && start_live && !pend_reg) begin
            pend_reg <= 1'b1;
            rnw_reg  <= RnW;
            bank_reg <= A[21:20];
        end else if (state_reg == ST_IDLE) begin
            if (pend_reg) begin
                pend_reg <= 1'b0;
            end else if (start_live) begin
                rnw_reg  <= RnW;
                bank_reg <= A[21:20];
            end
        end
    end

    // Outputs are decoded from the next state and registered, so nothing is combinational to the pins.
    always_comb begin
        en_n_next   = !(state_next == ST_SETUP || state_next == ST_STROBE || state_next == ST_ACK);
        read_n_next = !(rnw_reg && (state_next == ST_STROBE ||
                                    (state_next == ST_ACK && state_reg == ST_STROBE)));
        rst_n_next  = (state_next != ST_INIT_RST);
        ack_next    = (state_next == ST_ACK);
`ifdef FLASH_WRITE_EN
        write_n_next = !(!rnw_reg && state_next == ST_STROBE);
        wp_n_next    = !(state_next == ST_INIT_RST || state_next == ST_INIT_WAIT);
`else
        write_n_next = 1'b1;
        wp_n_next    = 1'b0;
`endif
    end

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            en_n_reg    <= 1'b1;
            read_n_reg  <= 1'b1;
            write_n_reg <= 1'b1;
            rst_n_reg   <= 1'b0;
            wp_n_reg    <= 1'b0;
            ack_reg     <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            en_n_reg    <= en_n_next;
            read_n_reg  <= read_n_next;
            write_n_reg <= write_n_next;
            rst_n_reg   <= rst_n_next;
            wp_n_reg    <= wp_n_next;
            ack_reg     <= ack_next;
            if (timeout_hit) timeout_reg <= 1'b1;
        end
    end

    assign F_ENn     = en_n_reg;
    assign F_READn   = read_n_reg;
    assign F_WRITEn  = write_n_reg;
    assign F_RSTn    = rst_n_reg;
    assign F_WPn     = wp_n_reg;
    assign F_BANK    = bank_reg;
    assign F_ACK     = ack_reg;
    assign F_TIMEOUT = timeout_reg;

endmodule

// File: tb/tb_u409_flash_ctrl.sv
// Directed bench for u409_flash_ctrl: reset sequencing, read/write timing,
// busy handling, timeout, back-to-back acceptance and mid-access reset.
module tb_u409_flash_ctrl;

    logic        CLK40, RESETn, TSn, RnW, FLASH_SPACE, F_RDY;
    logic [23:2] A;
    logic        F_ENn, F_READn, F_WRITEn, F_RSTn, F_WPn, F_ACK, F_TIMEOUT;
    logic [1:0]  F_BANK;

    int n_cmp = 0;
    int n_err = 0;

    int r_rd, r_wr, r_en, r_ack, r_ack_cyc, r_strb, r_both;

    u409_flash_ctrl dut (
        .CLK40       (CLK40),
        .RESETn      (RESETn),
        .TSn         (TSn),
        .RnW         (RnW),
        .FLASH_SPACE (FLASH_SPACE),
        .F_RDY       (F_RDY),
        .A           (A),
        .F_ENn       (F_ENn),
        .F_READn     (F_READn),
        .F_WRITEn    (F_WRITEn),
        .F_RSTn      (F_RSTn),
        .F_WPn       (F_WPn),
        .F_BANK      (F_BANK),
        .F_ACK       (F_ACK),
        .F_TIMEOUT   (F_TIMEOUT)
    );

    initial CLK40 = 1'b0;
    always #5 CLK40 = ~CLK40;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK40);
        #1;
    endtask

    // Starts one access on the next edge (cycle 1 = first cycle after that edge) and profiles ncyc cycles.
    task automatic do_access(input logic rnw, input logic [1:0] bank, input int ncyc, input int rdy_rel_c);
        r_rd = 0; r_wr = 0; r_en = 0; r_ack = 0; r_ack_cyc = 0; r_strb = 0; r_both = 0;
        RnW = rnw; A = '0; A[21:20] = bank; TSn = 1'b0; FLASH_SPACE = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (c == 1) begin TSn = 1'b1; FLASH_SPACE = 1'b0; end
            if (c == rdy_rel_c) F_RDY = 1'b1;
            if (F_READn === 1'b0) r_rd++;
            if (F_WRITEn === 1'b0) r_wr++;
            if (F_ENn === 1'b0) r_en++;
            if ((F_READn === 1'b0 || F_WRITEn === 1'b0) && r_strb == 0) r_strb = c;
            if (F_READn === 1'b0 && F_WRITEn === 1'b0) r_both++;
            if (F_ACK === 1'b1) begin r_ack++; r_ack_cyc = c; end
        end
        $display("access rnw=%0b bank=%0d: rd_low=%0d wr_low=%0d en_low=%0d acks=%0d ack_cyc=%0d strobe_at=%0d",
                 rnw, bank, r_rd, r_wr, r_en, r_ack, r_ack_cyc, r_strb);
    endtask

    task automatic test_reset();
        int low_cnt;
        logic exp_wp;
        RESETn = 1'b0; TSn = 1'b1; RnW = 1'b1; FLASH_SPACE = 1'b0; F_RDY = 1'b1; A = '0;
        repeat (3) tick();
        n_cmp++;
        if ({F_ENn, F_READn, F_WRITEn, F_RSTn, F_WPn, F_BANK, F_ACK, F_TIMEOUT} !== 9'b1_1_1_0_0_00_0_0) begin
            n_err++;
            $display("FAIL reset_values: got %b required %b",
                     {F_ENn, F_READn, F_WRITEn, F_RSTn, F_WPn, F_BANK, F_ACK, F_TIMEOUT}, 9'b111000000);
        end
        RESETn = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (F_RSTn === 1'b0) low_cnt++;
            else break;
        end
        n_cmp++;
        if (low_cnt !== 20) begin
            n_err++;
            $display("FAIL rst_hold: F_RSTn low %0d cycles, required 20", low_cnt);
        end
        n_cmp++;
        if (F_WPn !== 1'b0) begin
            n_err++;
            $display("FAIL wp_init_wait: got %b required 0", F_WPn);
        end
        tick();
`ifdef FLASH_WRITE_EN
        exp_wp = 1'b1;
`else
        exp_wp = 1'b0;
`endif
        n_cmp++;
        if (F_WPn !== exp_wp) begin
            n_err++;
            $display("FAIL wp_idle: got %b required %b", F_WPn, exp_wp);
        end
        $display("reset release: F_RSTn low %0d cycles", low_cnt);
    endtask

    // Issued right after test_reset: succeeds at cycle-exact timing only if IDLE was reached on schedule.
    task automatic test_read();
        do_access(1'b1, 2'b10, 8, 0);
        n_cmp++;
        if (F_BANK !== 2'd2) begin n_err++; $display("FAIL read_bank: got %0d required 2", F_BANK); end
        n_cmp++;
        if (r_rd !== 4) begin n_err++; $display("FAIL read_strobe_len: got %0d required 4", r_rd); end
        n_cmp++;
        if (r_ack !== 1 || r_ack_cyc !== 5) begin
            n_err++; $display("FAIL read_ack: got %0d acks at cycle %0d required 1 at cycle 5", r_ack, r_ack_cyc);
        end
        n_cmp++;
        if (r_en !== 5 || r_wr !== 0) begin
            n_err++; $display("FAIL read_en_wr: got en_low=%0d wr_low=%0d required 5 and 0", r_en, r_wr);
        end
    endtask

    task automatic test_write();
        int exp_wr, exp_ack, exp_en;
`ifdef FLASH_WRITE_EN
        exp_wr = 2; exp_ack = 4; exp_en = 4;
`else
        exp_wr = 0; exp_ack = 2; exp_en = 2;
`endif
        do_access(1'b0, 2'b01, 8, 0);
        n_cmp++;
        if (r_wr !== exp_wr) begin n_err++; $display("FAIL write_pulse: got %0d required %0d", r_wr, exp_wr); end
        n_cmp++;
        if (r_ack !== 1 || r_ack_cyc !== exp_ack) begin
            n_err++; $display("FAIL write_ack: got %0d acks at cycle %0d required 1 at cycle %0d", r_ack, r_ack_cyc, exp_ack);
        end
        n_cmp++;
        if (r_en !== exp_en || r_rd !== 0 || F_BANK !== 2'd1) begin
            n_err++; $display("FAIL write_en_rd_bank: got en=%0d rd=%0d bank=%0d required %0d 0 1", r_en, r_rd, F_BANK, exp_en);
        end
    endtask

    // TSn held low across ACK and RECOVER must be ignored, then accepted on the first IDLE edge.
    task automatic test_back_to_back();
        int acks = 0;
        int last_ack = 0;
        logic [2:0] en_seen = 3'b000;
        RnW = 1'b1; A = '0; TSn = 1'b0; FLASH_SPACE = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) begin TSn = 1'b1; FLASH_SPACE = 1'b0; end
            if (c == 5) begin TSn = 1'b0; FLASH_SPACE = 1'b1; end
            if (c == 8) begin TSn = 1'b1; FLASH_SPACE = 1'b0; end
            if (c == 6) en_seen[2] = F_ENn;
            if (c == 7) en_seen[1] = F_ENn;
            if (c == 8) en_seen[0] = F_ENn;
            if (F_ACK === 1'b1) begin acks++; last_ack = c; end
        end
        $display("back-to-back: en_n(c6..c8)=%b acks=%0d last_ack=%0d", en_seen, acks, last_ack);
        n_cmp++;
        if (en_seen !== 3'b110) begin n_err++; $display("FAIL b2b_accept: got en_n %b required 110", en_seen); end
        n_cmp++;
        if (acks !== 2 || last_ack !== 12) begin
            n_err++; $display("FAIL b2b_ack: got %0d acks last at %0d required 2 last at 12", acks, last_ack);
        end
    endtask

    task automatic test_busy_wait();
        F_RDY = 1'b0;
        repeat (3) tick();
        do_access(1'b1, 2'b00, 60, 50);
        n_cmp++;
        if (r_strb !== 53) begin n_err++; $display("FAIL busy_strobe_start: got cycle %0d required 53", r_strb); end
        n_cmp++;
        if (r_ack !== 1 || r_ack_cyc !== 56 || r_rd !== 4) begin
            n_err++; $display("FAIL busy_ack: got acks=%0d at %0d rd=%0d required 1 at 56 rd 4", r_ack, r_ack_cyc, r_rd);
        end
        n_cmp++;
        if (F_TIMEOUT !== 1'b0) begin n_err++; $display("FAIL busy_no_timeout: got %b required 0", F_TIMEOUT); end
    endtask

    task automatic test_timeout();
        F_RDY = 1'b0;
        repeat (3) tick();
        do_access(1'b1, 2'b11, 1030, 0);
        n_cmp++;
        if (r_ack !== 1 || r_ack_cyc !== 1024) begin
            n_err++; $display("FAIL timeout_ack: got %0d acks at %0d required 1 at 1024", r_ack, r_ack_cyc);
        end
        n_cmp++;
        if (r_rd !== 0 || r_wr !== 0 || r_en !== 1024) begin
            n_err++; $display("FAIL timeout_no_strobe: got rd=%0d wr=%0d en=%0d required 0 0 1024", r_rd, r_wr, r_en);
        end
        n_cmp++;
        if (F_TIMEOUT !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b required 1", F_TIMEOUT); end
    endtask

    task automatic test_reset_mid();
        int low_cnt;
        int acks = 0;
        F_RDY = 1'b1;
        repeat (3) tick();
        RnW = 1'b1; A = '0; A[21:20] = 2'b01; TSn = 1'b0; FLASH_SPACE = 1'b1;
        tick();
        TSn = 1'b1; FLASH_SPACE = 1'b0;
        tick();
        n_cmp++;
        if (F_READn !== 1'b0 || F_TIMEOUT !== 1'b1) begin
            n_err++; $display("FAIL midrst_in_strobe: got read_n=%b timeout=%b required 0 1", F_READn, F_TIMEOUT);
        end
        RESETn = 1'b0;
        tick();
        n_cmp++;
        if ({F_ENn, F_READn, F_WRITEn, F_RSTn, F_WPn, F_BANK, F_ACK, F_TIMEOUT} !== 9'b1_1_1_0_0_00_0_0) begin
            n_err++;
            $display("FAIL midrst_values: got %b required %b",
                     {F_ENn, F_READn, F_WRITEn, F_RSTn, F_WPn, F_BANK, F_ACK, F_TIMEOUT}, 9'b111000000);
        end
        F_RDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (F_ACK === 1'b1) acks++;
        end
        RESETn = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (F_ACK === 1'b1) acks++;
            if (F_RSTn === 1'b0) low_cnt++;
            else break;
        end
        $display("mid-access reset: F_RSTn low %0d cycles, acks=%0d", low_cnt, acks);
        n_cmp++;
        if (acks !== 0 || low_cnt !== 20) begin
            n_err++; $display("FAIL midrst_init: got acks=%0d rst_low=%0d required 0 and 20", acks, low_cnt);
        end
        // Start arrives while still in INIT_WAIT (flash busy) and must be replayed once IDLE is reached.
        do_access(1'b1, 2'b11, 14, 1);
        n_cmp++;
        if (F_BANK !== 2'd3 || r_strb !== 6) begin
            n_err++; $display("FAIL pending_strobe: got bank=%0d strobe_at=%0d required 3 and 6", F_BANK, r_strb);
        end
        n_cmp++;
        if (r_ack !== 1 || r_ack_cyc !== 9 || r_en !== 5) begin
            n_err++; $display("FAIL pending_ack: got acks=%0d at %0d en=%0d required 1 at 9 en 5", r_ack, r_ack_cyc, r_en);
        end
    endtask

    initial begin
        RESETn = 1'b0; TSn = 1'b1; RnW = 1'b1; FLASH_SPACE = 1'b0; F_RDY = 1'b1; A = '0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_busy_wait();
        test_timeout();
        test_reset_mid();
        n_cmp++;
        if (r_both !== 0) begin n_err++; $display("FAIL strobes_both_low: got %0d cycles required 0", r_both); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
